// File: rtl/input_quantize_packer.sv
// input_quantize_packer
//   Front-end of the classifier. Takes raw unsigned feature samples one per
//   beat, quantizes each to a 2-bit code against three thresholds, and packs
//   a frame of N_FEAT codes into a flat bus for the layer-0 LUT neuron array.
//   The packed frame is held stable until the consumer takes it, and frames
//   with the wrong number of beats are flagged.
//
// Ports
//   clk       in   1         clock, all state on rising edge
//   rst_n     in   1         asynchronous active-low reset
//   s_tdata   in   FEAT_W    raw feature value (unsigned)
//   s_tvalid  in   1         feature beat valid
//   s_tlast   in   1         last feature of a frame
//   s_tready  out  1         stage can accept a feature beat
//   m_data    out  2*N_FEAT  packed codes, feature i at [2i+1:2i]
//   m_valid   out  1         m_data holds a complete frame
//   m_ready   in   1         consumer accepts the frame
//   err_len   out  1         one-cycle pulse: frame length != N_FEAT
//   err_cnt   out  8         saturating count of err_len pulses
module input_quantize_packer #(
    parameter int unsigned N_FEAT = 16,
    parameter int unsigned FEAT_W = 8,
    parameter int unsigned THR0   = 64,
    parameter int unsigned THR1   = 128,
    parameter int unsigned THR2   = 192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FEAT_W-1:0]     s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [2*N_FEAT-1:0]   m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  err_len,
    output logic [7:0]            err_cnt
);

    localparam int unsigned IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic              accept;
    logic              wr_en;
    logic              err_nx;
    logic [1:0]        code;

    // Ready is forced low while reset is asserted, not only in HOLD.
    always_comb begin
        s_tready = rst_n && (state != HOLD);
        m_valid  = (state == HOLD);
        accept   = s_tvalid && s_tready;
    end

    always_comb begin
        code = 2'd0;
        if (s_tdata >= FEAT_W'(THR2))
            code = 2'd3;
        else if (s_tdata >= FEAT_W'(THR1))
            code = 2'd2;
        else if (s_tdata >= FEAT_W'(THR0))
            code = 2'd1;
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        wr_en    = 1'b0;
        err_nx   = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_nx = '0;
                        if (s_tlast) begin
                            state_nx = HOLD;
                        end else begin
                            // Frame is complete but too long: keep it, drop the rest.
                            state_nx = DRAIN;
                            err_nx   = 1'b1;
                        end
                    end else if (s_tlast) begin
                        // Short frame: restart; stale slots get overwritten before
                        // any frame is exposed.
                        idx_nx = '0;
                        err_nx = 1'b1;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && s_tlast)
                    state_nx = HOLD;
            end
            HOLD: begin
                if (m_ready) begin
                    state_nx = FILL;
                    idx_nx   = '0;
                end
            end
            default: begin
                state_nx = FILL;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= '0;
        end else begin
            for (int unsigned i = 0; i < N_FEAT; i++) begin
                if (wr_en && (idx == IDX_W'(i)))
                    m_data[2*i +: 2] <= code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_len <= err_nx;
            if (err_nx && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule
